// File: rtl/serial_product_collector_pkg.sv
// rtl/serial_product_collector_pkg.sv - shared types and width helpers for the serial product collector
package serial_product_collector_pkg;

    // Collector FSM states, fixed 2-bit encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spc_state_t;

    // Default operand width of the upstream shift-add multiplier
    localparam int DEFAULT_N = 32;

    // Parallel product width for an N-bit multiplier
    function automatic int calc_pw(input int n);
        return 2 * n;
    endfunction

    // Number of serial bits the multiplier emits per operation
    function automatic int calc_sb(input int n);
        return 2 * n - 1;
    endfunction

    // Bit counter width, enough to index every serial bit
    function automatic int calc_cw(input int n);
        return $clog2(2 * n - 1);
    endfunction

endpackage

// File: rtl/serial_product_collector.sv
// rtl/serial_product_collector.sv - assembles the multiplier's LSB-first serial product into a parallel word
module serial_product_collector
    import serial_product_collector_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    serial_in,
    output logic [calc_pw(N)-1:0]   prod,
    output logic                    prod_valid,
    input  logic                    prod_ready,
    output logic                    busy,
    output logic                    overrun
);

    localparam int PW = calc_pw(N);
    localparam int SB = calc_sb(N);
    localparam int CW = calc_cw(N);
    localparam logic [CW-1:0] LAST_IDX = CW'(SB - 1);

    spc_state_t      state;
    spc_state_t      state_nxt;
    logic [SB-1:0]   sr;
    logic [SB-1:0]   sr_next;
    logic [CW-1:0]   cnt;
    logic            last_bit;

    // New bits enter at the top so the first (LSB) bit ends up in sr[0]
    assign sr_next  = {serial_in, sr[SB-1:1]};
    assign last_bit = (cnt == LAST_IDX);

    assign prod_valid = (state == HOLD);
    assign busy       = (state == ALIGN) || (state == SHIFT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start always restarts alignment, mirroring the multiplier re-initialising
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ALIGN;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                ALIGN:   state_nxt = SHIFT;
                SHIFT:   if (last_bit) state_nxt = HOLD;
                HOLD:    if (prod_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: shift register, bit counter, product latch and sticky overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            cnt     <= '0;
            prod    <= '0;
            overrun <= 1'b0;
        end else if (start) begin
            sr  <= '0;
            cnt <= '0;
            // Only a held, unconsumed product can be lost; an aborted capture never was a result
            if ((state == HOLD) && !prod_ready) begin
                overrun <= 1'b1;
            end
        end else if (state == SHIFT) begin
            sr  <= sr_next;
            cnt <= cnt + 1'b1;
            if (last_bit) begin
                // Top product bit is never transmitted upstream, so it is zero-filled
                prod <= {1'b0, sr_next};
            end
        end
    end

endmodule

// File: tb/tb_serial_product_collector.sv
// tb/tb_serial_product_collector.sv - scoreboard bench for serial_product_collector at N=4 and N=32
module tb_serial_product_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // N=4 instance signals
    logic       rst4_n, st4, ser4, rdy4, v4, b4, o4;
    logic [7:0] p4;
    // N=32 instance signals
    logic        rst32_n, st32, ser32, rdy32, v32, b32, o32;
    logic [63:0] p32;

    // Scoreboards and a small model of the held/overrun state
    logic [7:0]  exp4[$];
    logic [63:0] exp32[$];
    bit          hold4;
    bit          ovr4;

    serial_product_collector #(.N(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst4_n),
        .start      (st4),
        .serial_in  (ser4),
        .prod       (p4),
        .prod_valid (v4),
        .prod_ready (rdy4),
        .busy       (b4),
        .overrun    (o4)
    );

    serial_product_collector #(.N(32)) dut32 (
        .clk        (clk),
        .rst_n      (rst32_n),
        .start      (st32),
        .serial_in  (ser32),
        .prod       (p32),
        .prod_valid (v32),
        .prod_ready (rdy32),
        .busy       (b32),
        .overrun    (o32)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset4();
        rst4_n = 1'b0;
        st4 = 1'b0; ser4 = 1'b0; rdy4 = 1'b0;
        exp4.delete();
        hold4 = 1'b0;
        ovr4 = 1'b0;
        repeat (2) tick();
        rst4_n = 1'b1;
    endtask

    task automatic reset32();
        rst32_n = 1'b0;
        st32 = 1'b0; ser32 = 1'b0; rdy32 = 1'b0;
        exp32.delete();
        repeat (2) tick();
        rst32_n = 1'b1;
    endtask

    // Pulse start, then drive the 7 serial bits one edge later, as the multiplier would
    task automatic send4(input logic [7:0] val);
        logic [7:0] e;
        if (hold4) begin
            if (rdy4) begin
                e = exp4.pop_front();
                checks++;
                if (p4 !== e) begin
                    errors++;
                    $display("FAIL consume_on_start prod got=%h exp=%h", p4, e);
                end
            end else begin
                void'(exp4.pop_front());
                ovr4 = 1'b1;
            end
        end
        st4 = 1'b1;
        tick();
        st4 = 1'b0;
        rdy4 = 1'b0;
        hold4 = 1'b0;
        exp4.push_back({1'b0, val[6:0]});
        checks++;
        if ({b4, v4, o4} !== {1'b1, 1'b0, ovr4}) begin
            errors++;
            $display("FAIL align_flags busy/valid/overrun got=%b exp=%b", {b4, v4, o4}, {1'b1, 1'b0, ovr4});
        end
        tick();
        for (int i = 0; i < 7; i++) begin
            ser4 = val[i];
            checks++;
            if ({b4, v4} !== 2'b10) begin
                errors++;
                $display("FAIL shift_flags bit %0d busy/valid got=%b exp=10", i, {b4, v4});
            end
            tick();
        end
        ser4 = 1'b0;
        hold4 = 1'b1;
        checks++;
        if ({b4, v4} !== 2'b01) begin
            errors++;
            $display("FAIL latency4 busy/valid after edge 8 got=%b exp=01", {b4, v4});
        end
    endtask

    // Hold prod_ready low for some cycles, then complete the handshake and compare
    task automatic collect4(input int hold_cycles);
        logic [7:0] e;
        if (exp4.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL collect4 scoreboard empty got=0 exp=1 entries");
            return;
        end
        e = exp4[0];
        for (int k = 0; k < hold_cycles; k++) begin
            checks++;
            if ({v4, p4} !== {1'b1, e}) begin
                errors++;
                $display("FAIL hold_stable cycle %0d valid/prod got=%b/%h exp=1/%h", k, v4, p4, e);
            end
            tick();
        end
        rdy4 = 1'b1;
        checks++;
        if ({v4, p4} !== {1'b1, e}) begin
            errors++;
            $display("FAIL prod4 valid/prod got=%b/%h exp=1/%h", v4, p4, e);
        end
        void'(exp4.pop_front());
        tick();
        rdy4 = 1'b0;
        hold4 = 1'b0;
        checks++;
        if ({v4, b4, p4} !== {1'b0, 1'b0, e}) begin
            errors++;
            $display("FAIL after_handshake valid/busy/prod got=%b/%b/%h exp=0/0/%h", v4, b4, p4, e);
        end
    endtask

    task automatic test_reset();
        reset4();
        reset32();
        checks++;
        if ({p4, v4, b4, o4} !== 11'd0) begin
            errors++;
            $display("FAIL reset4 outputs got=%h exp=0", {p4, v4, b4, o4});
        end
        checks++;
        if ({p32, v32, b32, o32} !== 67'd0) begin
            errors++;
            $display("FAIL reset32 outputs got=%h exp=0", {p32, v32, b32, o32});
        end
        rdy4 = 1'b1;
        tick();
        rdy4 = 1'b0;
        checks++;
        if ({v4, b4} !== 2'b00) begin
            errors++;
            $display("FAIL idle_ready_ignored valid/busy got=%b exp=00", {v4, b4});
        end
    endtask

    task automatic test_basic();
        send4(8'd35);
        collect4(0);
    endtask

    task automatic test_backpressure();
        send4(8'h7F);
        collect4(5);
    endtask

    task automatic test_start_with_ready();
        send4(8'h11);
        rdy4 = 1'b1;
        send4(8'h55);
        collect4(0);
        checks++;
        if (o4 !== 1'b0) begin
            errors++;
            $display("FAIL start_ready_overrun got=%b exp=0", o4);
        end
    endtask

    task automatic test_abort();
        st4 = 1'b1;
        tick();
        st4 = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            ser4 = 1'($urandom);
            tick();
        end
        send4(8'h15);
        collect4(0);
        checks++;
        if (o4 !== 1'b0) begin
            errors++;
            $display("FAIL abort_overrun got=%b exp=0", o4);
        end
    endtask

    task automatic test_long_start();
        st4 = 1'b1;
        repeat (2) tick();
        send4(8'h5A);
        collect4(1);
    endtask

    task automatic test_overrun();
        send4(8'h2A);
        send4(8'h03);
        collect4(0);
        checks++;
        if (o4 !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky got=%b exp=1", o4);
        end
    endtask

    task automatic test_reset_mid32();
        logic [63:0] val;
        logic [63:0] e;
        st32 = 1'b1;
        tick();
        st32 = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            ser32 = 1'($urandom);
            tick();
        end
        rst32_n = 1'b0;
        #1;
        checks++;
        if ({p32, v32, b32, o32} !== 67'd0) begin
            errors++;
            $display("FAIL mid_reset32 outputs got=%h exp=0", {p32, v32, b32, o32});
        end
        #2;
        rst32_n = 1'b1;
        ser32 = 1'b0;
        tick();
        val = 64'h0000_0001_0000_0001;
        st32 = 1'b1;
        tick();
        st32 = 1'b0;
        exp32.push_back({1'b0, val[62:0]});
        tick();
        for (int i = 0; i < 63; i++) begin
            ser32 = val[i];
            checks++;
            if ({b32, v32} !== 2'b10) begin
                errors++;
                $display("FAIL shift32 bit %0d busy/valid got=%b exp=10", i, {b32, v32});
            end
            tick();
        end
        ser32 = 1'b0;
        e = exp32.pop_front();
        checks++;
        if ({v32, p32} !== {1'b1, e}) begin
            errors++;
            $display("FAIL prod32 valid/prod got=%b/%h exp=1/%h", v32, p32, e);
        end
        rdy32 = 1'b1;
        tick();
        rdy32 = 1'b0;
        checks++;
        if ({v32, b32, o32} !== 3'b000) begin
            errors++;
            $display("FAIL handshake32 valid/busy/overrun got=%b exp=000", {v32, b32, o32});
        end
    endtask

    initial begin
        rst4_n = 1'b0; st4 = 1'b0; ser4 = 1'b0; rdy4 = 1'b0;
        rst32_n = 1'b0; st32 = 1'b0; ser32 = 1'b0; rdy32 = 1'b0;
        hold4 = 1'b0; ovr4 = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_start_with_ready();
        test_abort();
        test_long_start();
        test_overrun();
        test_reset_mid32();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
